// File: rtl/keypad_scan_ctrl_if.sv
// Keypad scan controller bus: the keypad-side inputs (det/col), the row drive,
// and the key-code valid/ready handshake toward the consumer.
// master = the scan controller, slave = keypad front end plus consumer.
interface keypad_scan_ctrl_if;
    logic       det_i;
    logic [3:0] col_i;
    logic [3:0] row_o;
    logic [3:0] key_o;
    logic       valid_o;
    logic       ready_i;
    logic       overrun_o;

    modport master (
        input  det_i, col_i, ready_i,
        output row_o, key_o, valid_o, overrun_o
    );

    modport slave (
        output det_i, col_i, ready_i,
        input  row_o, key_o, valid_o, overrun_o
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// Row-scan controller for a 4x4 matrix keypad. It drives one row at a time,
// captures row/column as a 4-bit code on a press, offers it on valid/ready,
// and holds the row until the key has been released, so one press gives one code.
// Optional build macro KEYPAD_FIFO_EN: the single output register becomes a
// 4-entry FIFO (valid = not empty, key = head, a transfer pops the head).
module keypad_scan_ctrl #(
    parameter int SCAN_DIV    = 50000,  // clocks per row dwell / release-check period, >= 2
    parameter int RELEASE_CNT = 8       // quiet periods in a row that mean "released", >= 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    keypad_scan_ctrl_if.master  bus
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int REL_W = $clog2(RELEASE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(SCAN_DIV - 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [DIV_W-1:0] div_cnt, div_nx;
    logic [REL_W-1:0] rel_cnt, rel_nx;
    logic [3:0]       row, row_nx;
    logic [1:0]       row_idx, idx_nx;
    logic [1:0]       col_idx;
    logic [3:0]       code;
    logic             tc;
    logic             push;
    logic             pop;

    assign tc   = (div_cnt == DIV_TC);
    assign code = {row_idx, col_idx};   // row_idx*4 + col_idx

    // Lowest set column wins; an all-zero column vector is handled as a glitch
    // by the FSM, so the value chosen here for it does not matter.
    always_comb begin
        col_idx = 2'd3;
        if      (bus.col_i[0]) col_idx = 2'd0;
        else if (bus.col_i[1]) col_idx = 2'd1;
        else if (bus.col_i[2]) col_idx = 2'd2;
    end

    // Next-state logic: dwell timing, row rotation, capture and release tracking.
    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        rel_nx   = rel_cnt;
        row_nx   = row;
        idx_nx   = row_idx;
        push     = 1'b0;
        case (state)
            SCAN: begin
                // det is only trusted at the end of a full dwell so the row has settled
                div_nx = tc ? '0 : div_cnt + DIV_W'(1);
                if (tc) begin
                    if (bus.det_i) begin
                        state_nx = CAPTURE;
                    end else begin
                        row_nx = {row[2:0], row[3]};
                        idx_nx = row_idx + 2'd1;
                    end
                end
            end
            CAPTURE: begin
                div_nx = '0;
                if (bus.col_i == 4'd0) begin
                    row_nx   = {row[2:0], row[3]};
                    idx_nx   = row_idx + 2'd1;
                    state_nx = SCAN;
                end else begin
                    push     = 1'b1;
                    rel_nx   = '0;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                div_nx = tc ? '0 : div_cnt + DIV_W'(1);
                if (tc) begin
                    if (bus.det_i) begin
                        rel_nx = '0;
                    end else if (rel_cnt == REL_LAST) begin
                        rel_nx   = '0;
                        row_nx   = {row[2:0], row[3]};
                        idx_nx   = row_idx + 2'd1;
                        state_nx = SCAN;
                    end else begin
                        rel_nx = rel_cnt + REL_W'(1);
                    end
                end
            end
            default: begin
                state_nx = SCAN;
                div_nx   = '0;
                rel_nx   = '0;
            end
        endcase
    end

    // Scan state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= SCAN;
            div_cnt <= '0;
            rel_cnt <= '0;
            row     <= 4'b0001;
            row_idx <= 2'd0;
        end else begin
            state   <= state_nx;
            div_cnt <= div_nx;
            rel_cnt <= rel_nx;
            row     <= row_nx;
            row_idx <= idx_nx;
        end
    end

    assign pop       = bus.valid_o && bus.ready_i;
    assign bus.row_o = row;

`ifdef KEYPAD_FIFO_EN
    logic [3:0][3:0] fifo_mem;
    logic [1:0]      rd_ptr, wr_ptr;
    logic [2:0]      fifo_cnt;
    logic            overrun;
    logic            push_ok;

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok = push && ((fifo_cnt != 3'd4) || pop);

    // Output FIFO; storage is cleared on reset so key_o reads 0 out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fifo_mem <= '0;
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            fifo_cnt <= 3'd0;
            overrun  <= 1'b0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= code;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (push && !push_ok) overrun <= 1'b1;
        end
    end

    assign bus.valid_o   = (fifo_cnt != 3'd0);
    assign bus.key_o     = fifo_mem[rd_ptr];
    assign bus.overrun_o = overrun;
`else
    logic [3:0] key_q;
    logic       valid_q;
    logic       overrun;

    // Single output slot; a capture may refill it on the same edge it is consumed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_q   <= 4'd0;
            valid_q <= 1'b0;
            overrun <= 1'b0;
        end else if (push && (!valid_q || bus.ready_i)) begin
            key_q   <= code;
            valid_q <= 1'b1;
        end else begin
            if (push) overrun <= 1'b1;
            if (pop)  valid_q <= 1'b0;
        end
    end

    assign bus.valid_o   = valid_q;
    assign bus.key_o     = key_q;
    assign bus.overrun_o = overrun;
`endif

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a directed vector table walking the main scenarios,
// an asynchronous-reset sequence, then randomized inputs against a queue-based model.
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV    = 4;
    localparam int RELEASE_CNT = 2;
`ifdef KEYPAD_FIFO_EN
    localparam bit FIFO  = 1'b1;
    localparam int DEPTH = 4;
`else
    localparam bit FIFO  = 1'b0;
    localparam int DEPTH = 1;
`endif
    // overrun expected after the second pending code only in single-slot builds
    localparam logic O1 = !FIFO;

    logic       clk = 1'b0;
    logic       rst;
    logic       det;
    logic [3:0] col;
    logic       ready;

    int n_cmp = 0;
    int n_err = 0;

    keypad_scan_ctrl_if bus();
    assign bus.det_i   = det;
    assign bus.col_i   = col;
    assign bus.ready_i = ready;

    keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .RELEASE_CNT(RELEASE_CNT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       det;
        logic [3:0] col;
        logic       rdy;
        int         n;
        logic [3:0] row;
        logic       vld;
        logic [3:0] key;
        logic       ovr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic d, logic [3:0] c, logic r, int n,
                                logic [3:0] rw, logic v, logic [3:0] k, logic o);
        vec_t t;
        t.det = d; t.col = c; t.rdy = r; t.n = n;
        t.row = rw; t.vld = v; t.key = k; t.ovr = o;
        return t;
    endfunction

    task automatic check(string name, logic [3:0] act, logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Row as an integer, the output slot as a queue of codes with capacity DEPTH.
    int m_phase;   // 0 scanning, 1 capture pending, 2 waiting for release
    int m_div, m_rel, m_row;
    bit m_ovr;
    int q[$];

    function automatic int lowest(logic [3:0] c);
        for (int i = 0; i < 4; i++) if (c[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_div = 0; m_rel = 0; m_row = 0; m_ovr = 0;
        q.delete();
    endtask

    task automatic model_step();
        int  code;
        bit  pop;
        bit  end_of_dwell;
        if (rst) begin
            model_reset();
            return;
        end
        code = -1;
        pop  = (q.size() > 0) && ready;
        end_of_dwell = (m_div == SCAN_DIV - 1);
        if (m_phase != 1) m_div = end_of_dwell ? 0 : m_div + 1;
        if (m_phase == 0) begin
            if (end_of_dwell) begin
                if (det) m_phase = 1;
                else     m_row = (m_row + 1) % 4;
            end
        end else if (m_phase == 1) begin
            if (col == 4'd0) begin
                m_row = (m_row + 1) % 4;
                m_phase = 0;
            end else begin
                code = m_row * 4 + lowest(col);
                m_rel = 0;
                m_phase = 2;
            end
        end else if (end_of_dwell) begin
            if (det) m_rel = 0;
            else begin
                m_rel++;
                if (m_rel == RELEASE_CNT) begin
                    m_row = (m_row + 1) % 4;
                    m_phase = 0;
                end
            end
        end
        if (pop) void'(q.pop_front());
        if (code >= 0) begin
            if (q.size() < DEPTH) q.push_back(code);
            else m_ovr = 1'b1;
        end
    endtask

    // One clock: model advances at the edge, bench returns at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; det = 1'b0; col = 4'd0; ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_key", bus.key_o, 4'h0);

        //           det col      rdy n  row      vld key   ovr
        tbl.push_back(mk(0, 4'b0000, 0, 0, 4'b0001, 0, 4'h0, 0));  // reset state
        tbl.push_back(mk(0, 4'b0000, 0, 4, 4'b0010, 0, 4'h0, 0));  // idle rotation
        tbl.push_back(mk(0, 4'b0000, 0, 4, 4'b0100, 0, 4'h0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 4, 4'b1000, 0, 4'h0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 4, 4'b0001, 0, 4'h0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 8, 4'b0100, 0, 4'h0, 0));
        tbl.push_back(mk(1, 4'b0010, 0, 4, 4'b0100, 0, 4'h0, 0));  // TC seen, in capture
        tbl.push_back(mk(1, 4'b0010, 0, 1, 4'b0100, 1, 4'h9, 0));  // code 9 valid
        tbl.push_back(mk(1, 4'b0010, 0, 3, 4'b0100, 1, 4'h9, 0));  // held while not ready
        tbl.push_back(mk(1, 4'b0010, 1, 1, 4'b0100, 0, 4'h0, 0));  // consumed
        tbl.push_back(mk(0, 4'b0000, 0, 7, 4'b0100, 0, 4'h0, 0));  // release, row held
        tbl.push_back(mk(0, 4'b0000, 0, 1, 4'b1000, 0, 4'h0, 0));  // 8th clock rotates
        tbl.push_back(mk(1, 4'b0000, 0, 4, 4'b1000, 0, 4'h0, 0));  // glitch: det w/o column
        tbl.push_back(mk(0, 4'b0000, 0, 1, 4'b0001, 0, 4'h0, 0));  // dropped, rotates
        tbl.push_back(mk(1, 4'b1000, 0, 5, 4'b0001, 1, 4'h3, 0));  // row0/col3 pending
        tbl.push_back(mk(0, 4'b0000, 0, 8, 4'b0010, 1, 4'h3, 0));
        tbl.push_back(mk(1, 4'b0001, 0, 5, 4'b0010, 1, 4'h3, O1)); // second code
        tbl.push_back(mk(0, 4'b0000, 0, 8, 4'b0100, 1, 4'h3, O1));
        tbl.push_back(mk(1, 4'b0100, 0, 5, 4'b0100, 1, 4'h3, O1)); // third code
        tbl.push_back(mk(0, 4'b0000, 0, 8, 4'b1000, 1, 4'h3, O1));
        tbl.push_back(mk(1, 4'b0001, 0, 5, 4'b1000, 1, 4'h3, O1)); // fourth code
        tbl.push_back(mk(0, 4'b0000, 0, 8, 4'b0001, 1, 4'h3, O1));
        tbl.push_back(mk(1, 4'b0010, 0, 5, 4'b0001, 1, 4'h3, 1));  // fifth: overrun in all builds

        foreach (tbl[i]) begin
            det = tbl[i].det; col = tbl[i].col; ready = tbl[i].rdy;
            repeat (tbl[i].n) tick();
            check($sformatf("vec%0d_row", i), bus.row_o, tbl[i].row);
            check($sformatf("vec%0d_valid", i), {3'b000, bus.valid_o}, {3'b000, tbl[i].vld});
            check($sformatf("vec%0d_overrun", i), {3'b000, bus.overrun_o}, {3'b000, tbl[i].ovr});
            if (tbl[i].vld) check($sformatf("vec%0d_key", i), bus.key_o, tbl[i].key);
        end

        // Reset in HOLD with a pending code: outputs clear without a clock edge.
        #2 rst = 1'b1;
        #1;
        check("async_rst_row", bus.row_o, 4'b0001);
        check("async_rst_valid", {3'b000, bus.valid_o}, 4'h0);
        check("async_rst_key", bus.key_o, 4'h0);
        check("async_rst_overrun", {3'b000, bus.overrun_o}, 4'h0);
        det = 1'b0; col = 4'd0; ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("post_rst_row", bus.row_o, 4'b0001);
        repeat (4) tick();
        check("post_rst_rotate", bus.row_o, 4'b0010);

        // Randomized inputs with occasional reset pulses, checked against the model.
        for (int c = 0; c < 4000; c++) begin
            rst   = ($urandom_range(0, 499) == 0);
            det   = ($urandom_range(0, 3) == 0);
            col   = 4'($urandom_range(0, 15));
            ready = $urandom_range(0, 1) == 1;
            tick();
            check("rand_row", bus.row_o, 4'(1 << m_row));
            check("rand_valid", {3'b000, bus.valid_o}, {3'b000, q.size() > 0});
            check("rand_overrun", {3'b000, bus.overrun_o}, {3'b000, m_ovr});
            if (q.size() > 0) check("rand_key", bus.key_o, 4'(q[0]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
